// File: rtl/mux4_rr_arbiter.sv
// Four-source round-robin arbiter feeding one registered valid/ready output stage.
// Per-requester payload gating lives in a lane sub-module; the top OR-combines the lanes.

module mux4_rr_arbiter_lane #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  sel_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic [DATA_WIDTH-1:0] data_o
);
  assign data_o = data_i & {DATA_WIDTH{sel_i}};
endmodule

module mux4_rr_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int FIXED_PRIO = 0
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic [3:0]              req_valid_i,
  input  logic [4*DATA_WIDTH-1:0] req_data_i,
  output logic [3:0]              req_ready_o,
  output logic                    out_valid_o,
  output logic [DATA_WIDTH-1:0]   out_data_o,
  output logic [1:0]              out_src_o,
  input  logic                    out_ready_i
);
  localparam int NUM_REQ = 4;

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_e;

  typedef struct packed {
    logic [1:0]            src;
    logic [DATA_WIDTH-1:0] data;
  } rsp_t;

  state_e state_q, state_d;
  rsp_t   rsp_q, rsp_d;
  logic [1:0] ptr_q, ptr_d;

  logic [NUM_REQ-1:0][DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0][DATA_WIDTH-1:0] lane_data;
  logic [NUM_REQ-1:0]                 win_oh;
  logic [DATA_WIDTH-1:0]              sel_data;
  logic [1:0]                         win, scan;
  logic                               found, any_vld, can_accept, accept;

  assign req_data = req_data_i;

  // Scan from the pointer upward; the first valid requester wins.
  always_comb begin
    win   = ptr_q;
    scan  = ptr_q;
    found = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      scan = ptr_q + 2'(i);
      if (!found && req_valid_i[scan]) begin
        win   = scan;
        found = 1'b1;
      end
    end
  end

  assign any_vld    = |req_valid_i;
  assign can_accept = (state_q == EMPTY) || out_ready_i;
  assign accept     = rst_ni && can_accept && any_vld;
  assign win_oh     = 4'b0001 << win;

  assign req_ready_o = accept ? win_oh : 4'b0000;

  for (genvar k = 0; k < NUM_REQ; k++) begin : g_lane
    mux4_rr_arbiter_lane #(.DATA_WIDTH(DATA_WIDTH)) u_lane (
      .sel_i  (win_oh[k]),
      .data_i (req_data[k]),
      .data_o (lane_data[k])
    );
  end

  always_comb begin
    sel_data = '0;
    for (int k = 0; k < NUM_REQ; k++) sel_data = sel_data | lane_data[k];
  end

  always_comb begin
    state_d = state_q;
    rsp_d   = rsp_q;
    ptr_d   = ptr_q;
    case (state_q)
      EMPTY:   if (accept) state_d = FULL;
      FULL:    if (!accept && out_ready_i) state_d = EMPTY;
      default: state_d = EMPTY;
    endcase
    if (accept) begin
      rsp_d.src  = win;
      rsp_d.data = sel_data;
      ptr_d      = (FIXED_PRIO != 0) ? 2'd0 : win + 2'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= EMPTY;
      rsp_q   <= '0;
      ptr_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      rsp_q   <= rsp_d;
      ptr_q   <= ptr_d;
    end
  end

  assign out_valid_o = (state_q == FULL);
  assign out_data_o  = rsp_q.data;
  assign out_src_o   = rsp_q.src;
endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Directed bench for mux4_rr_arbiter: one round-robin and one fixed-priority instance,
// expected transfers queued at grant time and popped by a monitor at each output handshake.

module tb_mux4_rr_arbiter;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  vld0 = '0, vld1 = '0;
  logic [31:0] dat0 = '0, dat1 = '0;
  logic        ordy0 = 1'b0, ordy1 = 1'b0;
  logic [3:0]  rr0, rr1;
  logic        ov0, ov1;
  logic [7:0]  od0, od1;
  logic [1:0]  os0, os1;

  int nvec = 0;
  int nerr = 0;
  logic [9:0] q0[$], q1[$];
  logic [9:0] e0, e1;

  always #5 clk = ~clk;

  mux4_rr_arbiter #(.DATA_WIDTH(8), .FIXED_PRIO(0)) dut (
    .clk_i(clk), .rst_ni(rst_n), .req_valid_i(vld0), .req_data_i(dat0),
    .req_ready_o(rr0), .out_valid_o(ov0), .out_data_o(od0), .out_src_o(os0),
    .out_ready_i(ordy0)
  );

  mux4_rr_arbiter #(.DATA_WIDTH(8), .FIXED_PRIO(1)) dut_fp (
    .clk_i(clk), .rst_ni(rst_n), .req_valid_i(vld1), .req_data_i(dat1),
    .req_ready_o(rr1), .out_valid_o(ov1), .out_data_o(od1), .out_src_o(os1),
    .out_ready_i(ordy1)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [1:0] oh2idx(input logic [3:0] oh);
    oh2idx = oh[1] ? 2'd1 : oh[2] ? 2'd2 : oh[3] ? 2'd3 : 2'd0;
  endfunction

  // One cycle: drive after the edge, check req_ready mid-cycle, queue the granted payload.
  task automatic cyc(input int d, input logic rst, input logic [3:0] v, input logic [31:0] dat,
                     input logic r, input logic [3:0] exp_rdy);
    logic [1:0] k;
    @(posedge clk); #1;
    rst_n = rst;
    if (d == 0) begin vld0 = v; dat0 = dat; ordy0 = r; end
    else        begin vld1 = v; dat1 = dat; ordy1 = r; end
    @(negedge clk);
    chk(d == 0 ? "req_ready" : "fp_req_ready", d == 0 ? rr0 : rr1, exp_rdy);
    if (exp_rdy != 4'b0000) begin
      k = oh2idx(exp_rdy);
      if (d == 0) q0.push_back({k, dat[k*8 +: 8]});
      else        q1.push_back({k, dat[k*8 +: 8]});
    end
  endtask

  always @(negedge clk) begin
    if (ov0 && ordy0) begin
      if (q0.size() == 0) begin
        nvec++; nerr++;
        $display("FAIL mon0: unexpected output src=%0d data=%h", os0, od0);
      end else begin
        e0 = q0.pop_front();
        chk("mon0_src", {30'd0, os0}, {30'd0, e0[9:8]});
        chk("mon0_data", {24'd0, od0}, {24'd0, e0[7:0]});
      end
    end
    if (ov1 && ordy1) begin
      if (q1.size() == 0) begin
        nvec++; nerr++;
        $display("FAIL mon1: unexpected output src=%0d data=%h", os1, od1);
      end else begin
        e1 = q1.pop_front();
        chk("mon1_src", {30'd0, os1}, {30'd0, e1[9:8]});
        chk("mon1_data", {24'd0, od1}, {24'd0, e1[7:0]});
      end
    end
  end

  localparam logic [31:0] PAY = 32'h13121110;

  initial begin
    // reset with requests pending: no grants, outputs cleared
    cyc(0, 1'b0, 4'hF, PAY, 1'b1, 4'b0000);
    cyc(0, 1'b0, 4'hF, PAY, 1'b1, 4'b0000);
    chk("rst_valid", {31'd0, ov0}, 32'd0);
    chk("rst_data", {24'd0, od0}, 32'd0);
    chk("rst_src", {30'd0, os0}, 32'd0);

    // single requester 2, then requester 3 moves ptr back to 0
    cyc(0, 1'b1, 4'b0100, 32'h00A50000, 1'b1, 4'b0100);
    cyc(0, 1'b1, 4'b1000, PAY, 1'b1, 4'b1000);
    chk("t1_valid", {31'd0, ov0}, 32'd1);
    chk("t1_data", {24'd0, od0}, 32'h000000A5);
    chk("t1_src", {30'd0, os0}, 32'd2);

    // all valid: fair rotation 0,1,2,3,0,1,2,3
    for (int i = 0; i < 2; i++) begin
      cyc(0, 1'b1, 4'hF, PAY, 1'b1, 4'b0001);
      cyc(0, 1'b1, 4'hF, PAY, 1'b1, 4'b0010);
      cyc(0, 1'b1, 4'hF, PAY, 1'b1, 4'b0100);
      cyc(0, 1'b1, 4'hF, PAY, 1'b1, 4'b1000);
    end

    // reach FULL with src 1, then stall three cycles
    cyc(0, 1'b1, 4'hF, PAY, 1'b1, 4'b0001);
    cyc(0, 1'b1, 4'hF, PAY, 1'b1, 4'b0010);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 1'b1, 4'hF, PAY, 1'b0, 4'b0000);
      chk("stall_valid", {31'd0, ov0}, 32'd1);
      chk("stall_src", {30'd0, os0}, 32'd1);
      chk("stall_data", {24'd0, od0}, 32'h11);
    end
    cyc(0, 1'b1, 4'hF, PAY, 1'b1, 4'b0100);

    // drain without refill; payload retained
    cyc(0, 1'b1, 4'b0000, PAY, 1'b1, 4'b0000);
    cyc(0, 1'b1, 4'b0000, PAY, 1'b1, 4'b0000);
    chk("drain_valid", {31'd0, ov0}, 32'd0);
    chk("drain_data", {24'd0, od0}, 32'h12);
    chk("drain_src", {30'd0, os0}, 32'd2);

    // ptr (3) survives idle cycles: scan 3,0 -> 0
    cyc(0, 1'b1, 4'b0011, PAY, 1'b1, 4'b0001);
    // requester 3 withdraws while stalled; ptr stays at 1
    cyc(0, 1'b1, 4'b1000, PAY, 1'b0, 4'b0000);
    cyc(0, 1'b1, 4'b0000, PAY, 1'b1, 4'b0000);
    cyc(0, 1'b1, 4'b0101, PAY, 1'b1, 4'b0100);

    // reset while FULL and stalled discards the payload; ptr restarts at 0
    cyc(0, 1'b0, 4'hF, PAY, 1'b0, 4'b0000);
    q0.delete();
    cyc(0, 1'b1, 4'b1001, PAY, 1'b1, 4'b0001);
    chk("mrst_valid", {31'd0, ov0}, 32'd0);
    chk("mrst_data", {24'd0, od0}, 32'd0);
    chk("mrst_src", {30'd0, os0}, 32'd0);
    cyc(0, 1'b1, 4'b0000, PAY, 1'b1, 4'b0000);
    cyc(0, 1'b1, 4'b0000, PAY, 1'b1, 4'b0000);
    chk("end_valid", {31'd0, ov0}, 32'd0);

    // fixed priority: requester 1 always beats 3
    for (int i = 0; i < 3; i++) cyc(1, 1'b1, 4'b1010, PAY, 1'b1, 4'b0010);
    cyc(1, 1'b1, 4'b1000, PAY, 1'b1, 4'b1000);
    cyc(1, 1'b1, 4'b1010, PAY, 1'b1, 4'b0010);
    cyc(1, 1'b1, 4'b1010, PAY, 1'b1, 4'b0010);
    cyc(1, 1'b1, 4'b0000, PAY, 1'b1, 4'b0000);
    cyc(1, 1'b1, 4'b0000, PAY, 1'b1, 4'b0000);
    chk("fp_end_valid", {31'd0, ov1}, 32'd0);

    chk("q0_empty", q0.size(), 32'd0);
    chk("q1_empty", q1.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/mux4_rr_arbiter.md
Name: mux4_rr_arbiter

Overview:
- Four-requester round-robin arbiter that shares one DATA_WIDTH output channel between four valid/ready sources.
- Selects one source per transfer and steers its payload through 4:1 selection into a single registered output stage.
- Sits in front of any shared consumer (writeback port, memory request port) that is fed by a 4x1 select.

Parameters:
DATA_WIDTH, 8, width of each requester payload and of out_data_o
FIXED_PRIO, 0, 0 = round-robin pointer; 1 = pointer held at 0 (strict priority, requester 0 highest)

Ports:
clk_i  input  1  clock; all state updates on rising edge
rst_ni  input  1  synchronous reset, active-low
req_valid_i  input  4  per-requester valid; bit k = requester k
req_data_i  input  4*DATA_WIDTH  packed payloads; requester k at bits [k*DATA_WIDTH +: DATA_WIDTH]
req_ready_o  output  4  one-hot or zero; bit k high = requester k's payload accepted this cycle
out_valid_o  output  1  output register holds a valid payload
out_data_o  output  DATA_WIDTH  registered payload
out_src_o  output  2  index of the requester whose payload is in out_data_o
out_ready_i  input  1  consumer accepts out_data_o this cycle

Behaviour:
- Reset (rst_ni=0 at clock edge): out_valid_o=0, out_data_o=0, out_src_o=0, rr pointer=0. req_ready_o=0 while rst_ni=0, regardless of other inputs.
- States, encoded by out_valid_o: EMPTY (0), FULL (1).
- can_accept = !out_valid_o || out_ready_i, evaluated combinationally.
- Winner: first k with req_valid_i[k]=1, scanning ptr, ptr+1, ptr+2, ptr+3 (mod 4).
- req_ready_o[winner] = can_accept && |req_valid_i. All other bits are 0. There is a combinational path from out_ready_i and req_valid_i to req_ready_o; no path from req_ready_o to any input.
- Accept (can_accept and any valid), at the next edge:
  - out_data_o <= payload of winner (4:1 select on winner index)
  - out_src_o <= winner
  - out_valid_o <= 1
  - ptr <= (winner+1) mod 4 when FIXED_PRIO=0; ptr stays 0 when FIXED_PRIO=1
- Drain without refill (out_valid_o && out_ready_i && no valid): out_valid_o <= 0. out_data_o and out_src_o hold their last values.
- FULL and !out_ready_i: all outputs hold, req_ready_o=0, ptr holds.
- Latency: 1 cycle from accept to out_valid_o.
- Throughput: 1 transfer per cycle; simultaneous drain and refill in one cycle is required and produces no bubble.
- ptr advances only on accept, never on idle cycles. A requester that deasserts before being granted loses nothing and does not change ptr.
- Fairness: with all four requesters continuously valid and out_ready_i=1, grant order is 0,1,2,3,0,...; any valid requester waits at most 3 transfers.
- Requesters may change data or drop valid at any time before acceptance; the arbiter does not require requester-side stability.
- Reset mid-transfer discards the held payload (out_valid_o=0 the cycle after the reset edge). No req_ready_o is issued during reset.
- out_src_o never carries an X; the winner index width is 2 bits and wraps from 3 to 0.

Test Plan:
- Reset, then req_valid_i=4'b0100 with payload 2 = 8'hA5, out_ready_i=1 -> req_ready_o=4'b0100 in the same cycle; next cycle out_valid_o=1, out_data_o=8'hA5, out_src_o=2; ptr=3.
- All four valid (payloads 8'h10, 8'h11, 8'h12, 8'h13), out_ready_i=1 held for 8 cycles -> out_src_o sequence 0,1,2,3,0,1,2,3 with matching data, out_valid_o=1 continuously.
- FULL with out_src_o=1, out_ready_i=0 for 3 cycles while all requesters are valid -> req_ready_o=0 and outputs stable for those 3 cycles; first cycle with out_ready_i=1 -> req_ready_o=4'b0100 and refill in the same cycle.
- FIXED_PRIO=1, req_valid_i=4'b1010 repeated -> requester 1 always granted; requester 3 granted only when req_valid_i=4'b1000.
- Single transfer, then req_valid_i=0 with out_ready_i=1 -> out_valid_o drops to 0 one cycle after the drain; out_data_o retains its value.
- rst_ni=0 asserted while FULL with out_ready_i=0 -> next cycle out_valid_o=0, out_data_o=0, out_src_o=0, req_ready_o=0; after release, ptr restarts at 0.
